seq_divider: RTL and testbench



---
 rtl/seq_divider.sv | 153 +++++++++++++++
 tb/tb_seq_divider.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider: one quotient bit per clock, valid/ready in and out.
// Define DIV_SIGNED_EN to add truncating signed division selected per operation by signed_i.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  input  logic             signed_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             div_by_zero_o
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;

  // Working registers: partial remainder, dividend shifting into quotient, divisor magnitude
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvs;

  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;
  logic             dbz_q;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             qbit;
  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] dvd_nxt;
  logic [WIDTH-1:0] op_dividend;
  logic [WIDTH-1:0] op_divisor;
  logic [WIDTH-1:0] res_quotient;
  logic [WIDTH-1:0] res_remainder;

`ifdef DIV_SIGNED_EN
  logic neg_q;
  logic neg_r;

  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v,
                                                 input logic en);
    if (en && v[WIDTH-1]) begin
      return -v;
    end
    return v;
  endfunction

  function automatic logic [WIDTH-1:0] negate_if(input logic [WIDTH-1:0] v, input logic neg);
    if (neg) begin
      return -v;
    end
    return v;
  endfunction

  assign op_dividend   = magnitude(dividend_i, signed_i);
  assign op_divisor    = magnitude(divisor_i, signed_i);
  assign res_quotient  = negate_if(dvd_nxt, neg_q);
  assign res_remainder = negate_if(rem_nxt, neg_r);
`else
  logic unused_signed;

  assign unused_signed = signed_i;
  assign op_dividend   = dividend_i;
  assign op_divisor    = divisor_i;
  assign res_quotient  = dvd_nxt;
  assign res_remainder = rem_nxt;
`endif

  // One restoring step: shift in the next dividend bit, keep the trial difference if non-negative
  always_comb begin
    shifted = {rem, dvd[WIDTH-1]};
    trial   = shifted - {1'b0, dvs};
    qbit    = ~trial[WIDTH];
    rem_nxt = qbit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    dvd_nxt = {dvd[WIDTH-2:0], qbit};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      cnt         <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (valid_i) begin
            if (divisor_i == '0) begin
              quotient_q  <= '1;
              remainder_q <= dividend_i;
              dbz_q       <= 1'b1;
              state       <= DONE;
            end else begin
              cnt   <= CNT_W'(WIDTH - 1);
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          if (cnt == '0) begin
            quotient_q  <= res_quotient;
            remainder_q <= res_remainder;
            dbz_q       <= 1'b0;
            state       <= DONE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        DONE: begin
          if (ready_i) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (state == IDLE && valid_i) begin
      rem <= '0;
      dvd <= op_dividend;
      dvs <= op_divisor;
`ifdef DIV_SIGNED_EN
      neg_q <= signed_i && (dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1]);
      neg_r <= signed_i && dividend_i[WIDTH-1];
`endif
    end else if (state == BUSY) begin
      rem <= rem_nxt;
      dvd <= dvd_nxt;
    end
  end

  assign ready_o       = (state == IDLE);
  assign valid_o       = (state == DONE);
  assign quotient_o    = quotient_q;
  assign remainder_o   = remainder_q;
  assign div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider (WIDTH=32) with hand-computed quotient/remainder vectors.
module tb_seq_divider;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic        ready_o;
  logic [31:0] dividend_i;
  logic [31:0] divisor_i;
  logic        signed_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] quotient_o;
  logic [31:0] remainder_o;
  logic        div_by_zero_o;

  int total = 0;
  int bad   = 0;
  int lat;

  seq_divider #(.WIDTH(32)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .dividend_i   (dividend_i),
    .divisor_i    (divisor_i),
    .signed_i     (signed_i),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .quotient_o   (quotient_o),
    .remainder_o  (remainder_o),
    .div_by_zero_o(div_by_zero_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s);
    int n;
    n = 0;
    while (ready_o !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    check("ready_before_issue", ready_o, 1'b1);
    valid_i    = 1'b1;
    dividend_i = a;
    divisor_i  = b;
    signed_i   = s;
    tick();
    valid_i  = 1'b0;
    signed_i = 1'b0;
  endtask

  task automatic wait_result(output int n);
    n = 0;
    while (valid_o !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
  endtask

  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic s, input logic [31:0] eq, input logic [31:0] er,
                       input logic edbz, input int elat);
    int n;
    issue(a, b, s);
    wait_result(n);
    check({tag, "_latency"}, n, elat);
    check({tag, "_quotient"}, quotient_o, eq);
    check({tag, "_remainder"}, remainder_o, er);
    check({tag, "_dbz"}, div_by_zero_o, edbz);
    check({tag, "_ready_in_done"}, ready_o, 1'b0);
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
    check({tag, "_valid_after_drain"}, valid_o, 1'b0);
    check({tag, "_ready_after_drain"}, ready_o, 1'b1);
  endtask

  initial begin
    rst_i      = 1'b1;
    valid_i    = 1'b0;
    ready_i    = 1'b0;
    dividend_i = '0;
    divisor_i  = '0;
    signed_i   = 1'b0;
    repeat (3) tick();
    check("rst_ready", ready_o, 1'b1);
    check("rst_valid", valid_o, 1'b0);
    check("rst_quotient", quotient_o, 32'h0);
    check("rst_remainder", remainder_o, 32'h0);
    check("rst_dbz", div_by_zero_o, 1'b0);
    rst_i = 1'b0;
    tick();

    do_op("u100_7", 32'd100, 32'd7, 1'b0, 32'h0000000E, 32'h00000002, 1'b0, 32);
    do_op("max_by_1", 32'hFFFFFFFF, 32'h1, 1'b0, 32'hFFFFFFFF, 32'h0, 1'b0, 32);
    do_op("five_by_9", 32'h5, 32'h9, 1'b0, 32'h0, 32'h5, 1'b0, 32);
    do_op("div0", 32'h00001234, 32'h0, 1'b0, 32'hFFFFFFFF, 32'h00001234, 1'b1, 0);
    do_op("u_neg_big", 32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h0, 32'h80000000, 1'b0, 32);
    do_op("u1000_33", 32'd1000, 32'd33, 1'b0, 32'd30, 32'd10, 1'b0, 32);
`ifdef DIV_SIGNED_EN
    do_op("s_m7_2", 32'hFFFFFFF9, 32'h2, 1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 32);
    do_op("s_ovf", 32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'h0, 1'b0, 32);
`else
    do_op("s_m7_2", 32'hFFFFFFF9, 32'h2, 1'b1, 32'h7FFFFFFC, 32'h00000001, 1'b0, 32);
`endif
    do_op("s_div0", 32'hFFFFFFF9, 32'h0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFF9, 1'b1, 0);

    // Backpressure with a stray valid_i pulse during BUSY
    issue(32'd1000, 32'd33, 1'b0);
    repeat (5) tick();
    valid_i    = 1'b1;
    dividend_i = 32'd7;
    divisor_i  = 32'd0;
    tick();
    valid_i = 1'b0;
    check("bp_ready_busy", ready_o, 1'b0);
    wait_result(lat);
    check("bp_latency", lat, 26);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_valid_hold", valid_o, 1'b1);
      check("bp_quotient_hold", quotient_o, 32'd30);
      check("bp_remainder_hold", remainder_o, 32'd10);
      check("bp_dbz_hold", div_by_zero_o, 1'b0);
    end
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
    check("bp_valid_drained", valid_o, 1'b0);
    repeat (40) tick();
    check("bp_no_second_result", valid_o, 1'b0);
    check("bp_ready_idle", ready_o, 1'b1);
    check("bp_outputs_kept", quotient_o, 32'd30);

    // Reset in the middle of an iteration
    issue(32'd100, 32'd7, 1'b0);
    repeat (10) tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check("mid_rst_ready", ready_o, 1'b1);
    check("mid_rst_valid", valid_o, 1'b0);
    check("mid_rst_quotient", quotient_o, 32'h0);
    check("mid_rst_remainder", remainder_o, 32'h0);
    check("mid_rst_dbz", div_by_zero_o, 1'b0);
    repeat (40) tick();
    check("mid_rst_no_result", valid_o, 1'b0);

    do_op("after_rst", 32'd50, 32'd6, 1'b0, 32'd8, 32'd2, 1'b0, 32);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
